// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-enable generator: output mode encodings
// and the divisor clamp that maps a programmed 0 onto divide-by-1.
package clk_gen_pkg;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // Divisors of 0 and 1 both mean "every cycle", so 0 is clamped to 1.
  // Callers size-cast in and out, which limits divisor width to 32 bits.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clk_enable_ch.sv
// One divider channel: terminal counter, active/pending divisor pair,
// registered tick and toggle flops, and the pulse/square output select.
module clk_enable_ch
  import clk_gen_pkg::*;
#(
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  input  logic             mode_i,
  output logic             tick_o,
  output logic             out_o,
  output logic             div_pending_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             toggle_q, toggle_d;

  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] term_cnt;
  logic             apply_pend;

  assign eff_div  = DIV_W'(clamp_div(32'(div_act_q)));
  assign term_cnt = eff_div - DIV_W'(1);

  // NOTE: every variable gets a default before the priority chain so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    toggle_d     = toggle_q;
    div_act_d    = div_act_q;
    div_pend_d   = div_pend_q;
    pend_valid_d = pend_valid_q;
    apply_pend   = 1'b0;

    if (sync_clr_i) begin
      cnt_d      = '0;
      toggle_d   = 1'b0;
      apply_pend = 1'b1;
    end else if (!en_i) begin
      apply_pend = 1'b1;
    end else if (cnt_q >= term_cnt) begin
      // >= rather than == keeps a held count above a freshly shrunk
      // divisor from running all the way round the counter.
      cnt_d      = '0;
      tick_d     = 1'b1;
      toggle_d   = ~toggle_q;
      apply_pend = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // Only the previously pending value is applied; a load on this same
    // edge is queued behind it and waits for the next application point.
    if (apply_pend && pend_valid_q) begin
      div_act_d    = div_pend_q;
      pend_valid_d = 1'b0;
    end
    if (div_load_i) begin
      div_pend_d   = div_i;
      pend_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      div_act_q    <= DEFAULT_DIV;
      div_pend_q   <= '0;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      toggle_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_act_q    <= div_act_d;
      div_pend_q   <= div_pend_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      toggle_q     <= toggle_d;
    end
  end

  // Mode only steers the output; cnt and toggle run regardless of it.
  always_comb begin
    out_o = tick_q;
    case (mode_i)
      MODE_PULSE:  out_o = tick_q;
      MODE_SQUARE: out_o = toggle_q;
    endcase
  end

  assign tick_o        = tick_q;
  assign div_pending_o = pend_valid_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable / divided-clock generator; channels share only
// the clock, reset and the phase-aligning synchronous clear.
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       mode,
  input  logic                    sync_clr,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       out,
  output logic [NUM_CH-1:0]       div_pending
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_enable_ch #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DIV_W'(DEFAULT_DIV))
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en[k]),
      .sync_clr_i   (sync_clr),
      .div_i        (div_in[k*DIV_W +: DIV_W]),
      .div_load_i   (div_load[k]),
      .mode_i       (mode[k]),
      .tick_o       (tick[k]),
      .out_o        (out[k]),
      .div_pending_o(div_pending[k])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: two 16-bit channels, default divide-by-2.
module tb_clk_enable_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic [31:0] div_in;
  logic [1:0]  div_load;
  logic [1:0]  mode;
  logic        sync_clr;
  logic [1:0]  tick;
  logic [1:0]  out;
  logic [1:0]  div_pending;

  int vectors = 0;
  int miscompares = 0;

  clk_enable_gen #(.NUM_CH(2), .DIV_W(16), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_in(div_in), .div_load(div_load),
    .mode(mode), .sync_clr(sync_clr), .tick(tick), .out(out), .div_pending(div_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_div(input int ch, input logic [15:0] val);
    div_in[ch*16 +: 16] = val;
    div_load[ch] = 1'b1;
    step();
    div_load[ch] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = '0; div_in = '0; div_load = '0; mode = '0; sync_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    rst_n = 1'b0; en = '0; div_in = '0; div_load = '0; mode = '0; sync_clr = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (tick !== 2'b00) begin miscompares++; $display("FAIL reset_tick: got %b want 00", tick); end
    vectors++; if (out !== 2'b00) begin miscompares++; $display("FAIL reset_out: got %b want 00", out); end
    vectors++; if (div_pending !== 2'b00) begin miscompares++; $display("FAIL reset_pending: got %b want 00", div_pending); end
    en = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp = (i % 2 == 0) ? 2'b11 : 2'b00;
      vectors++; if (tick !== exp) begin miscompares++; $display("FAIL legacy_tick edge %0d: got %b want %b", i, tick, exp); end
      vectors++; if (out !== exp) begin miscompares++; $display("FAIL legacy_out edge %0d: got %b want %b", i, out, exp); end
    end
  endtask

  task automatic test_div_update();
    logic exp_t [11];
    logic exp_p;
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    load_div(0, 16'd3);
    step();
    vectors++; if (div_pending[0] !== 1'b0) begin miscompares++; $display("FAIL upd_applied_idle: got %b want 0", div_pending[0]); end
    en = 2'b01;
    for (int i = 1; i <= 11; i++) begin
      step();
      exp_p = (i == 5);
      vectors++; if (tick[0] !== exp_t[i-1]) begin miscompares++; $display("FAIL upd_tick edge %0d: got %b want %b", i, tick[0], exp_t[i-1]); end
      vectors++; if (div_pending[0] !== exp_p) begin miscompares++; $display("FAIL upd_pending edge %0d: got %b want %b", i, div_pending[0], exp_p); end
      if (i == 4) begin div_in[15:0] = 16'd5; div_load[0] = 1'b1; end
      if (i == 5) div_load[0] = 1'b0;
    end
  endtask

  task automatic test_square();
    logic exp_t, exp_o;
    do_reset();
    load_div(1, 16'd4);
    step();
    mode = 2'b10;
    en = 2'b10;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_t = (i % 4 == 0);
      exp_o = ((i / 4) % 2 == 1);
      vectors++; if (tick[1] !== exp_t) begin miscompares++; $display("FAIL sq_tick edge %0d: got %b want %b", i, tick[1], exp_t); end
      vectors++; if (out[1] !== exp_o) begin miscompares++; $display("FAIL sq_out edge %0d: got %b want %b", i, out[1], exp_o); end
    end
    step();
    vectors++; if (out[1] !== 1'b1) begin miscompares++; $display("FAIL sq_out edge 13: got %b want 1", out[1]); end
    mode[1] = 1'b0; #1;
    vectors++; if (out[1] !== 1'b0) begin miscompares++; $display("FAIL mode_to_pulse: got %b want 0", out[1]); end
    mode[1] = 1'b1; #1;
    vectors++; if (out[1] !== 1'b1) begin miscompares++; $display("FAIL mode_to_square: got %b want 1", out[1]); end
    step(); step();
    vectors++; if (out[1] !== 1'b1) begin miscompares++; $display("FAIL sq_out edge 15: got %b want 1", out[1]); end
    step();
    vectors++; if (tick[1] !== 1'b1) begin miscompares++; $display("FAIL sq_tick edge 16: got %b want 1", tick[1]); end
    vectors++; if (out[1] !== 1'b0) begin miscompares++; $display("FAIL sq_out edge 16: got %b want 0", out[1]); end
  endtask

  task automatic test_div_zero_one();
    logic exp_tog;
    do_reset();
    mode = 2'b01;
    load_div(0, 16'd0);
    step();
    en = 2'b01;
    exp_tog = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_tog = ~exp_tog;
      vectors++; if (tick[0] !== 1'b1) begin miscompares++; $display("FAIL div0_tick edge %0d: got %b want 1", i, tick[0]); end
      vectors++; if (out[0] !== exp_tog) begin miscompares++; $display("FAIL div0_out edge %0d: got %b want %b", i, out[0], exp_tog); end
    end
    div_in[15:0] = 16'd1;
    div_load[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      div_load[0] = 1'b0;
      exp_tog = ~exp_tog;
      vectors++; if (tick[0] !== 1'b1) begin miscompares++; $display("FAIL div1_tick edge %0d: got %b want 1", i, tick[0]); end
      vectors++; if (out[0] !== exp_tog) begin miscompares++; $display("FAIL div1_out edge %0d: got %b want %b", i, out[0], exp_tog); end
      vectors++; if (div_pending[0] !== (i == 1)) begin miscompares++; $display("FAIL div1_pending edge %0d: got %b want %b", i, div_pending[0], (i == 1)); end
    end
  endtask

  task automatic test_sync_clr();
    logic [1:0] exp_t, exp_o;
    do_reset();
    div_in = {16'd7, 16'd3};
    div_load = 2'b11;
    step();
    div_load = 2'b00;
    step();
    en = 2'b11;
    mode = 2'b11;
    repeat (5) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    vectors++; if (tick !== 2'b00) begin miscompares++; $display("FAIL clr_tick: got %b want 00", tick); end
    vectors++; if (out !== 2'b00) begin miscompares++; $display("FAIL clr_out: got %b want 00", out); end
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_t = {(i == 7), (i == 3 || i == 6)};
      exp_o = {(i == 7), (i >= 3 && i < 6)};
      vectors++; if (tick !== exp_t) begin miscompares++; $display("FAIL align_tick edge %0d: got %b want %b", i, tick, exp_t); end
      vectors++; if (out !== exp_o) begin miscompares++; $display("FAIL align_out edge %0d: got %b want %b", i, out, exp_o); end
    end
  endtask

  task automatic test_en_hold_and_async_reset();
    do_reset();
    load_div(0, 16'd5);
    step();
    en = 2'b01;
    for (int i = 1; i <= 7; i++) begin
      step();
      vectors++; if (tick[0] !== (i == 5)) begin miscompares++; $display("FAIL run_tick edge %0d: got %b want %b", i, tick[0], (i == 5)); end
    end
    en = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      step();
      vectors++; if (tick[0] !== 1'b0) begin miscompares++; $display("FAIL hold_tick edge %0d: got %b want 0", i, tick[0]); end
    end
    en = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++; if (tick[0] !== (i == 3)) begin miscompares++; $display("FAIL resume_tick edge %0d: got %b want %b", i, tick[0], (i == 3)); end
    end
    en = 2'b11;
    mode = 2'b10;
    step(); step();
    load_div(0, 16'd9);
    vectors++; if (div_pending[0] !== 1'b1) begin miscompares++; $display("FAIL pre_rst_pending: got %b want 1", div_pending[0]); end
    vectors++; if (out[1] !== 1'b1) begin miscompares++; $display("FAIL pre_rst_out: got %b want 1", out[1]); end
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (tick !== 2'b00) begin miscompares++; $display("FAIL async_rst_tick: got %b want 00", tick); end
    vectors++; if (out !== 2'b00) begin miscompares++; $display("FAIL async_rst_out: got %b want 00", out); end
    vectors++; if (div_pending !== 2'b00) begin miscompares++; $display("FAIL async_rst_pending: got %b want 00", div_pending); end
    mode = 2'b00;
    en = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++; if (tick[0] !== (i % 2 == 0)) begin miscompares++; $display("FAIL default_div edge %0d: got %b want %b", i, tick[0], (i % 2 == 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_div_update();
    test_square();
    test_div_zero_one();
    test_sync_clr();
    test_en_hold_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
